// File: rtl/bus_map_pkg.sv
// Shared types and helpers for the bus_mem_map fabric: FSM states,
// per-region configuration record and the address decoder.
package bus_map_pkg;

  localparam int MAX_REGIONS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // One decoded window of the 16-bit address space.
  typedef struct packed {
    logic [15:0] base;
    logic [3:0]  size_log2;
    logic        ro;
    logic [1:0]  wait_st;
  } region_cfg_t;

  typedef region_cfg_t [MAX_REGIONS-1:0] region_map_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } decode_t;

  // Region match on the address bits above the region size; the scan runs
  // downwards so the lowest matching index is the one left standing.
  function automatic decode_t decode(input logic [15:0] ab,
                                     input region_map_t cfg,
                                     input int          num);
    decode_t r;
    r = '0;
    for (int i = MAX_REGIONS - 1; i >= 0; i--) begin
      if (i < num) begin
        if ((ab >> cfg[i].size_log2) == (cfg[i].base >> cfg[i].size_log2)) begin
          r.hit = 1'b1;
          r.idx = 3'(i);
        end
      end
    end
    return r;
  endfunction

  // Byte offset of an address inside a region of 2**size_log2 bytes.
  function automatic logic [14:0] region_offset(input logic [15:0] ab,
                                                input logic [3:0]  size_log2);
    logic [15:0] mask;
    mask = (16'd1 << size_log2) - 16'd1;
    return 15'(ab & mask);
  endfunction

endpackage

// File: rtl/bus_mem_region.sv
// Single-port synchronous byte RAM for one decoded region, with a backdoor
// write port used for preloading. The backdoor wins a same-address write
// collision; a bus read at the same edge returns the pre-write contents.
module bus_mem_region
  import bus_map_pkg::*;
#(
  parameter int SIZE_LOG2 = 12
) (
  input  logic                 clk,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [SIZE_LOG2-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           rdata,
  input  logic                 bd_we,
  input  logic [SIZE_LOG2-1:0] bd_addr,
  input  logic [7:0]           bd_data
);

  logic [7:0] mem [2**SIZE_LOG2];

  // Bus write, then backdoor write (later assignment wins), registered read.
  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
    if (bd_we) mem[bd_addr] <= bd_data;
    if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_mem_map.sv
// Configurable memory-map fabric between the 65C02 bus pins and storage.
// Parameters are packed with region 0 in the least significant slice:
//   REGION_BASE      16 bits per region
//   REGION_SIZE_LOG2  4 bits per region
//   REGION_RO         1 bit  per region
//   REGION_WAIT       2 bits per region
//   access_cnt    CNT_W bits per region
// Handshake: the core presents AB/WE/DO every cycle; an access is accepted
// whenever the fabric is in IDLE and completes when RDY is high after the
// completion edge. While RDY is low the bus inputs are ignored and the
// latched access is replayed at the completion edge.
module bus_mem_map
  import bus_map_pkg::*;
#(
  parameter int                         NUM_REGIONS      = 4,
  parameter logic [NUM_REGIONS*16-1:0]  REGION_BASE      = {16'hC000, 16'h9000, 16'h8000, 16'h0000},
  parameter logic [NUM_REGIONS*4-1:0]   REGION_SIZE_LOG2 = {4'd14, 4'd12, 4'd12, 4'd15},
  parameter logic [NUM_REGIONS-1:0]     REGION_RO        = 4'b1000,
  parameter logic [NUM_REGIONS*2-1:0]   REGION_WAIT      = {2'd0, 2'd0, 2'd0, 2'd0},
  parameter logic [7:0]                 UNMAPPED_DATA    = 8'hFF,
  parameter int                         CNT_W            = 16,
  parameter logic [15:0]                HALT_ADDR        = 16'hFFFF,
  parameter int                         HALT_DELAY       = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [15:0]                  AB,
  input  logic [7:0]                   DO,
  input  logic                         WE,
  output logic [7:0]                   DI,
  output logic                         RDY,
  output logic                         halt,
  output logic                         err_ro,
  output logic                         err_unmapped,
  output logic [NUM_REGIONS*CNT_W-1:0] access_cnt,
  input  logic                         bd_we,
  input  logic [2:0]                   bd_region,
  input  logic [14:0]                  bd_addr,
  input  logic [7:0]                   bd_data
);

  localparam logic [7:0]  RESET_DI  = 8'hEA;
  localparam logic [15:0] HALT_LOAD = 16'(HALT_DELAY - 1);

  region_map_t cfg;
  decode_t     dec;
  logic [14:0] cur_off;

  state_t      state, state_n;
  logic [1:0]  wcnt, wcnt_n;

  logic [2:0]  lat_idx;
  logic [14:0] lat_off;
  logic        lat_we;
  logic [7:0]  lat_do;

  logic        do_access;
  logic        do_unmapped;
  logic        acc_go;
  logic [2:0]  acc_idx;
  logic [14:0] acc_off;
  logic        acc_we;
  logic [7:0]  acc_do;

  logic        rdy;
  logic        di_from_ram;
  logic [2:0]  di_idx;
  logic [7:0]  di_const;
  logic [7:0]  rdata [MAX_REGIONS];

  logic [CNT_W-1:0] cnt [NUM_REGIONS];

  logic        halt_armed;
  logic [15:0] halt_cnt;

  // Unpack the flat parameters into per-region records; unused slots are zero.
  for (genvar g = 0; g < MAX_REGIONS; g++) begin : g_cfg
    if (g < NUM_REGIONS) begin : g_on
      assign cfg[g] = '{base:      REGION_BASE[g*16 +: 16],
                        size_log2: REGION_SIZE_LOG2[g*4 +: 4],
                        ro:        REGION_RO[g],
                        wait_st:   REGION_WAIT[g*2 +: 2]};
    end else begin : g_off
      assign cfg[g] = '0;
    end
  end

  // Decode the live bus address.
  always_comb begin
    dec     = decode(AB, cfg, NUM_REGIONS);
    cur_off = region_offset(AB, cfg[dec.idx].size_log2);
  end

  // Next state and the access that completes at the coming edge.
  always_comb begin
    state_n     = state;
    wcnt_n      = wcnt;
    do_access   = 1'b0;
    do_unmapped = 1'b0;
    acc_idx     = dec.idx;
    acc_off     = cur_off;
    acc_we      = WE;
    acc_do      = DO;
    case (state)
      IDLE: begin
        if (dec.hit) begin
          if (cfg[dec.idx].wait_st == 2'd0) begin
            do_access = 1'b1;
          end else begin
            state_n = WAIT;
            wcnt_n  = cfg[dec.idx].wait_st;
          end
        end else begin
          do_unmapped = 1'b1;
        end
      end
      WAIT: begin
        acc_idx = lat_idx;
        acc_off = lat_off;
        acc_we  = lat_we;
        acc_do  = lat_do;
        if (wcnt > 2'd1) begin
          wcnt_n = wcnt - 2'd1;
        end else begin
          do_access = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Storage never commits on a reset edge, so an aborted wait leaves no trace.
  assign acc_go = do_access & ~reset;

  // State register; the access is latched on the edge that enters WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= 2'd0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      if (state == IDLE && state_n == WAIT) begin
        lat_idx <= dec.idx;
        lat_off <= cur_off;
        lat_we  <= WE;
        lat_do  <= DO;
      end
    end
  end

  // One RAM per configured region.
  for (genvar g = 0; g < MAX_REGIONS; g++) begin : g_mem
    if (g < NUM_REGIONS) begin : g_on
      localparam int SZ = int'(REGION_SIZE_LOG2[g*4 +: 4]);
      logic rd, wr, bdw;
      assign rd  = acc_go && (acc_idx == 3'(g)) && !acc_we;
      assign wr  = acc_go && (acc_idx == 3'(g)) && acc_we && !REGION_RO[g];
      assign bdw = bd_we && (bd_region == 3'(g)) && ((bd_addr >> SZ) == 15'd0);
      bus_mem_region #(.SIZE_LOG2(SZ)) u_mem (
        .clk     (clk),
        .rd_en   (rd),
        .wr_en   (wr),
        .addr    (acc_off[SZ-1:0]),
        .wdata   (acc_do),
        .rdata   (rdata[g]),
        .bd_we   (bdw),
        .bd_addr (bd_addr[SZ-1:0]),
        .bd_data (bd_data)
      );
    end else begin : g_off
      assign rdata[g] = '0;
    end
  end

  // Core-facing ready, read-data source select and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdy          <= 1'b1;
      di_from_ram  <= 1'b0;
      di_idx       <= 3'd0;
      di_const     <= RESET_DI;
      err_ro       <= 1'b0;
      err_unmapped <= 1'b0;
    end else begin
      rdy <= (state_n == IDLE);
      if (do_access && !acc_we) begin
        di_from_ram <= 1'b1;
        di_idx      <= acc_idx;
      end
      if (do_access && acc_we && cfg[acc_idx].ro) err_ro <= 1'b1;
      if (do_unmapped) begin
        err_unmapped <= 1'b1;
        if (!WE) begin
          di_from_ram <= 1'b0;
          di_const    <= UNMAPPED_DATA;
        end
      end
    end
  end

  assign RDY = rdy;
  assign DI  = di_from_ram ? rdata[di_idx] : di_const;

  // Saturating per-region completed-access counters.
  always_ff @(posedge clk) begin
    for (int g = 0; g < NUM_REGIONS; g++) begin
      if (reset) begin
        cnt[g] <= '0;
      end else if (do_access && acc_idx == 3'(g) && cnt[g] != '1) begin
        cnt[g] <= cnt[g] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_cnt
    assign access_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end

  // Halt: arm on the first sighting of HALT_ADDR, raise halt HALT_DELAY edges later.
  always_ff @(posedge clk) begin
    if (reset) begin
      halt       <= 1'b0;
      halt_armed <= 1'b0;
      halt_cnt   <= 16'd0;
    end else if (!halt_armed) begin
      if (AB == HALT_ADDR) begin
        halt_armed <= 1'b1;
        if (HALT_DELAY == 0) halt <= 1'b1;
        else                 halt_cnt <= HALT_LOAD;
      end
    end else if (!halt) begin
      if (halt_cnt == 16'd0) halt <= 1'b1;
      else                   halt_cnt <= halt_cnt - 16'd1;
    end
  end

endmodule

// File: tb/tb_bus_mem_map.sv
// Directed bench for bus_mem_map with a transaction-level reference model.
module tb_bus_mem_map;

  localparam int NR = 4;
  localparam int CW = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   AB;
  logic [7:0]    DO;
  logic          WE;
  logic [7:0]    DI;
  logic          RDY;
  logic          halt;
  logic          err_ro;
  logic          err_unmapped;
  logic [NR*CW-1:0] access_cnt;
  logic          bd_we;
  logic [2:0]    bd_region;
  logic [14:0]   bd_addr;
  logic [7:0]    bd_data;

  always #5 clk = ~clk;

  bus_mem_map #(
    .NUM_REGIONS      (NR),
    .REGION_BASE      ({16'hC000, 16'h9000, 16'h8000, 16'h0000}),
    .REGION_SIZE_LOG2 ({4'd14, 4'd12, 4'd12, 4'd15}),
    .REGION_RO        (4'b1000),
    .REGION_WAIT      ({2'd1, 2'd2, 2'd0, 2'd3}),
    .UNMAPPED_DATA    (8'hFF),
    .CNT_W            (CW),
    .HALT_ADDR        (16'hFFFF),
    .HALT_DELAY       (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .AB           (AB),
    .DO           (DO),
    .WE           (WE),
    .DI           (DI),
    .RDY          (RDY),
    .halt         (halt),
    .err_ro       (err_ro),
    .err_unmapped (err_unmapped),
    .access_cnt   (access_cnt),
    .bd_we        (bd_we),
    .bd_region    (bd_region),
    .bd_addr      (bd_addr),
    .bd_data      (bd_data)
  );

  // ---------------- reference model ----------------
  int m_base [NR] = '{32'h0000, 32'h8000, 32'h9000, 32'hC000};
  int m_size [NR] = '{32768, 4096, 4096, 16384};
  bit m_ro   [NR] = '{1'b0, 1'b0, 1'b0, 1'b1};
  int m_wait [NR] = '{3, 0, 2, 1};

  logic [7:0] mem [NR][32768];
  logic [7:0] exp_di;
  bit         exp_rdy, exp_halt, exp_ero, exp_eun;
  int         exp_cnt [NR];
  int         edge_no;
  bit         halt_seen;
  int         halt_edge;

  // access completing at the next edge
  bit         p_done, p_hit, p_we, p_rdy;
  int         p_idx, p_off;
  logic [7:0] p_do;

  logic [7:0] exp_q [$];

  int  errors = 0;
  int  checks = 0;
  bit  chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Range-based lookup, lowest region first.
  task automatic lookup(input logic [15:0] a, output bit hit, output int idx);
    hit = 1'b0;
    idx = 0;
    for (int i = 0; i < NR; i++) begin
      if (!hit && int'(a) >= m_base[i] && int'(a) < m_base[i] + m_size[i]) begin
        hit = 1'b1;
        idx = i;
      end
    end
  endtask

  // Advance one clock edge and apply its effects to the model.
  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
    if (reset) begin
      exp_di    = 8'hEA;
      exp_rdy   = 1'b1;
      exp_halt  = 1'b0;
      exp_ero   = 1'b0;
      exp_eun   = 1'b0;
      halt_seen = 1'b0;
      for (int i = 0; i < NR; i++) exp_cnt[i] = 0;
    end else begin
      if (!halt_seen && AB == 16'hFFFF) begin
        halt_seen = 1'b1;
        halt_edge = edge_no;
      end
      exp_rdy = p_rdy;
      if (p_done) begin
        if (p_hit) begin
          if (exp_cnt[p_idx] < (1 << CW) - 1) exp_cnt[p_idx]++;
          if (p_we) begin
            if (m_ro[p_idx]) exp_ero = 1'b1;
            else             mem[p_idx][p_off] = p_do;
          end else begin
            exp_di = mem[p_idx][p_off];
            exp_q.push_back(exp_di);
          end
        end else begin
          exp_eun = 1'b1;
          if (!p_we) begin
            exp_di = 8'hFF;
            exp_q.push_back(exp_di);
          end
        end
      end
      exp_halt = halt_seen && (edge_no - halt_edge >= 5);
    end
    if (bd_we) begin
      if (bd_region < 3'(NR) && int'(bd_addr) < m_size[bd_region]) mem[bd_region][bd_addr] = bd_data;
      bd_we = 1'b0;
    end
    p_done = 1'b0;
    p_rdy  = 1'b1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic bd(input logic [2:0] r, input logic [14:0] a, input logic [7:0] d);
    bd_we     = 1'b1;
    bd_region = r;
    bd_addr   = a;
    bd_data   = d;
  endtask

  // One complete bus access; with scramble the bus lines change during waits.
  task automatic access(input logic [15:0] a, input bit w, input logic [7:0] d,
                        input bit scramble = 1'b0);
    bit hit;
    int idx;
    int wt;
    lookup(a, hit, idx);
    AB = a;
    WE = w;
    DO = d;
    wt = hit ? m_wait[idx] : 0;
    for (int e = 0; e < wt; e++) begin
      p_done = 1'b0;
      p_rdy  = 1'b0;
      step();
      if (scramble) begin
        AB = 16'hA000;
        WE = ~w;
        DO = ~d;
      end
    end
    p_done = 1'b1;
    p_hit  = hit;
    p_idx  = idx;
    p_off  = hit ? int'(a) - m_base[idx] : 0;
    p_we   = w;
    p_do   = d;
    p_rdy  = 1'b1;
    step();
  endtask

  // ---------------- scoreboard: every cycle ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("RDY", 32'(RDY), 32'(exp_rdy));
      chk("DI", 32'(DI), 32'(exp_di));
      chk("halt", 32'(halt), 32'(exp_halt));
      chk("err_ro", 32'(err_ro), 32'(exp_ero));
      chk("err_unmapped", 32'(err_unmapped), 32'(exp_eun));
      for (int r = 0; r < NR; r++)
        chk($sformatf("access_cnt[%0d]", r), 32'(access_cnt[r*CW +: CW]), 32'(exp_cnt[r]));
      while (exp_q.size() > 0) chk("read_data", 32'(DI), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1; AB = 16'h8000; WE = 1'b0; DO = 8'h00;
    bd_we = 1'b0; bd_region = 3'd0; bd_addr = 15'd0; bd_data = 8'h00;
    exp_di = 8'hEA; exp_rdy = 1'b1; exp_halt = 1'b0; exp_ero = 1'b0; exp_eun = 1'b0;
    for (int i = 0; i < NR; i++) exp_cnt[i] = 0;
    edge_no = 0; halt_seen = 1'b0; halt_edge = 0;
    p_done = 1'b0; p_rdy = 1'b1; p_hit = 1'b0; p_we = 1'b0; p_idx = 0; p_off = 0; p_do = 8'h00;

    // preload through the backdoor while in reset
    bd(3'd1, 15'h000, 8'h01); step();
    chk_en = 1'b1;
    bd(3'd1, 15'h010, 8'h5A); step();
    bd(3'd3, 15'h000, 8'hA5); step();
    bd(3'd3, 15'h3FFF, 8'h60); step();
    bd(3'd0, 15'h0100, 8'h22); step();
    bd(3'd1, 15'h030, 8'h33); step();
    chk("reset_DI", 32'(DI), 32'h EA);
    chk("reset_RDY", 32'(RDY), 32'd1);
    chk("reset_cnt", 32'(access_cnt), 32'd0);
    reset = 1'b0;

    // W=0 read
    access(16'h8010, 1'b0, 8'h00);
    chk("w0_read_DI", 32'(DI), 32'h5A);
    chk("w0_read_cnt1", 32'(access_cnt[1*CW +: CW]), 32'd1);

    // W=2 write (bus lines disturbed during waits), then read back
    access(16'h9004, 1'b1, 8'h3C, 1'b1);
    chk("wait_ignores_bus", 32'(err_unmapped), 32'd0);
    access(16'h9004, 1'b0, 8'h00);
    chk("w2_readback", 32'(DI), 32'h3C);

    // read-only write is dropped
    access(16'hC000, 1'b1, 8'h11);
    chk("ro_err", 32'(err_ro), 32'd1);
    chk("ro_cnt3", 32'(access_cnt[3*CW +: CW]), 32'd1);
    access(16'hC000, 1'b0, 8'h00);
    chk("ro_unchanged", 32'(DI), 32'hA5);

    // unmapped read and write
    access(16'hA000, 1'b0, 8'h00);
    chk("unmapped_DI", 32'(DI), 32'hFF);
    chk("unmapped_err", 32'(err_unmapped), 32'd1);
    access(16'hA001, 1'b1, 8'h44);
    chk("unmapped_wr_DI", 32'(DI), 32'hFF);

    // backdoor beats a colliding bus write
    bd(3'd1, 15'h020, 8'h55);
    access(16'h8020, 1'b1, 8'hAA);
    access(16'h8020, 1'b0, 8'h00);
    chk("bd_wins", 32'(DI), 32'h55);
    // colliding bus read sees old data
    bd(3'd1, 15'h030, 8'h99);
    access(16'h8030, 1'b0, 8'h00);
    chk("bd_read_old", 32'(DI), 32'h33);
    access(16'h8030, 1'b0, 8'h00);
    chk("bd_read_new", 32'(DI), 32'h99);
    // out-of-range backdoor region and offset are ignored
    bd(3'd5, 15'h010, 8'hEE);
    access(16'h8010, 1'b0, 8'h00);
    bd(3'd1, 15'h1010, 8'hEE);
    access(16'h8010, 1'b0, 8'h00);
    access(16'h8010, 1'b0, 8'h00);
    chk("bd_oor_ignored", 32'(DI), 32'h5A);
    // backdoor writes a read-only region
    bd(3'd3, 15'h000, 8'hB6);
    access(16'h8000, 1'b0, 8'h00);
    access(16'hC000, 1'b0, 8'h00);
    chk("bd_ro_bypass", 32'(DI), 32'hB6);

    // reset in the middle of a W=3 write
    AB = 16'h0100; WE = 1'b1; DO = 8'h77;
    p_done = 1'b0; p_rdy = 1'b0; step();
    p_done = 1'b0; p_rdy = 1'b0; step();
    reset = 1'b1;
    step();
    chk("abort_RDY", 32'(RDY), 32'd1);
    chk("abort_DI", 32'(DI), 32'hEA);
    chk("abort_cnt0", 32'(access_cnt[0 +: CW]), 32'd0);
    reset = 1'b0;
    access(16'h0100, 1'b0, 8'h00);
    chk("abort_no_commit", 32'(DI), 32'h22);

    // counter saturation on region 0
    for (int i = 0; i < 20; i++) access(16'h0200, 1'b1, 8'(i));
    chk("cnt0_saturated", 32'(access_cnt[0 +: CW]), 32'hF);

    // halt five edges after the first sighting of 16'hFFFF
    access(16'hFFFF, 1'b0, 8'h00);
    chk("halt_addr_DI", 32'(DI), 32'h60);
    for (int i = 0; i < 3; i++) access(16'h8000, 1'b0, 8'h00);
    chk("halt_early", 32'(halt), 32'd0);
    access(16'h8000, 1'b0, 8'h00);
    chk("halt_rise", 32'(halt), 32'd1);
    for (int i = 0; i < 4; i++) access(16'h8010, 1'b0, 8'h00);
    chk("halt_hold", 32'(halt), 32'd1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
